// File: rtl/ntt_bram_arbiter_if.sv
// ntt_bram_arbiter_if: requester ports and BRAM port bundle for ntt_bram_arbiter
interface ntt_bram_arbiter_if #(
   parameter int DATA_W  = 64,
   parameter int ADDR_W  = 13,
   parameter int BRAM_AW = 15
);
   logic              r0_req, r0_we, r0_gnt, r0_rvalid;
   logic [ADDR_W-1:0] r0_addr;
   logic [DATA_W-1:0] r0_wdata, r0_rdata;
   logic              r1_req, r1_we, r1_gnt, r1_rvalid;
   logic [ADDR_W-1:0] r1_addr;
   logic [DATA_W-1:0] r1_wdata, r1_rdata;
   logic [BRAM_AW-1:0] BRAM_addr;
   logic              BRAM_clk, BRAM_en, BRAM_we;
   logic [DATA_W-1:0] BRAM_din, BRAM_dout;
   logic              busy;
   modport slave (
      input  r0_req, r0_we, r0_addr, r0_wdata, r1_req, r1_we, r1_addr, r1_wdata, BRAM_dout,
      output r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
      output BRAM_addr, BRAM_clk, BRAM_en, BRAM_we, BRAM_din, busy
   );
   modport master (
      output r0_req, r0_we, r0_addr, r0_wdata, r1_req, r1_we, r1_addr, r1_wdata,
      input  r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata, busy
   );
endinterface

// File: rtl/ntt_bram_arbiter.sv
// ntt_bram_arbiter: shares one BRAM port between two requesters, returns read data in issue order
// Define ARB_FIXED_PRIO_EN for strict port 0 priority; default is round-robin.
module ntt_bram_arbiter #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 13,
   parameter int BRAM_AW  = 15,
   parameter int READ_LAT = 3
) (
   input logic clk,
   input logic rst,
   ntt_bram_arbiter_if.slave bus
);
   logic                lp, g0, g1, iport, en, we;
   logic [BRAM_AW-1:0]  addr;
   logic [DATA_W-1:0]   din;
   logic [READ_LAT-1:0] pv, pp;
   // Grant selection, forced low while reset is held
   always_comb begin
`ifdef ARB_FIXED_PRIO_EN
      g0 = rst && bus.r0_req;
      g1 = rst && bus.r1_req && !bus.r0_req;
`else
      g0 = rst && bus.r0_req && (!bus.r1_req || lp);
      g1 = rst && bus.r1_req && (!bus.r0_req || !lp);
`endif
   end
   assign bus.r0_gnt    = g0;
   assign bus.r1_gnt    = g1;
   assign bus.BRAM_clk  = clk;
   assign bus.BRAM_en   = en;
   assign bus.BRAM_we   = we;
   assign bus.BRAM_addr = addr;
   assign bus.BRAM_din  = din;
   assign bus.r0_rvalid = pv[READ_LAT-1] && !pp[READ_LAT-1];
   assign bus.r1_rvalid = pv[READ_LAT-1] && pp[READ_LAT-1];
   assign bus.r0_rdata  = bus.BRAM_dout;
   assign bus.r1_rdata  = bus.BRAM_dout;
   assign bus.busy      = |pv;
   // Issue stage: register the granted transaction onto the BRAM port; address/data hold when idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lp    <= 1'b1;
         iport <= 1'b0;
         en    <= 1'b0;
         we    <= 1'b0;
         addr  <= '0;
         din   <= '0;
      end else begin
         en <= g0 || g1;
         we <= g1 ? bus.r1_we : g0 && bus.r0_we;
         if (g0 || g1) begin
            lp    <= g1;
            iport <= g1;
            addr  <= BRAM_AW'({g1 ? bus.r1_addr : bus.r0_addr, 2'b00});
            din   <= g1 ? bus.r1_wdata : bus.r0_wdata;
         end
      end
   end
   // Return pipe: each issued read carries its port tag until the BRAM data arrives
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pv <= '0;
         pp <= '0;
      end else begin
         pv[0] <= en && !we;
         pp[0] <= iport;
         for (int i = 1; i < READ_LAT; i++) begin
            pv[i] <= pv[i-1];
            pp[i] <= pp[i-1];
         end
      end
   end
endmodule

// File: tb/tb_ntt_bram_arbiter.sv
// tb_ntt_bram_arbiter: directed scoreboard bench for ntt_bram_arbiter
module tb_ntt_bram_arbiter;
   localparam int DW = 64, AW = 13, BAW = 15, LAT = 3;
`ifdef ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif
   typedef struct { logic [DW-1:0] d; int c; } exp_t;
   logic clk = 0, rst = 1;
   logic sg0, sg1;
   logic [DW-1:0] e0, e1;
   logic [DW-1:0] mem [0:(1<<(BAW-2))-1];
   logic [DW-1:0] rq [LAT];
   exp_t q0[$], q1[$];
   int checks = 0, errors = 0, cyc = 0, n0, n1;
   always #5 clk = ~clk;
   ntt_bram_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .BRAM_AW(BAW)) bus();
   ntt_bram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .BRAM_AW(BAW), .READ_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   // BRAM model with fixed read latency, read-before-write on the same edge
   always @(posedge bus.BRAM_clk) begin
      if (bus.BRAM_en && bus.BRAM_we) mem[bus.BRAM_addr[BAW-1:2]] <= bus.BRAM_din;
      rq[0] <= (bus.BRAM_en && !bus.BRAM_we) ? mem[bus.BRAM_addr[BAW-1:2]] : '0;
      for (int i = 1; i < LAT; i++) rq[i] <= rq[i-1];
   end
   assign bus.BRAM_dout = rq[LAT-1];
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask
   // Monitor: pop expected read data whenever a port presents rvalid
   always @(negedge clk) begin
      exp_t e;
      if (bus.r0_rvalid) begin
         if (q0.size() == 0) chk("r0 unexpected rvalid", 1, 0);
         else begin
            e = q0.pop_front();
            chk("r0 rdata", bus.r0_rdata, e.d);
            chk("r0 latency", 64'(cyc), 64'(e.c));
         end
      end
      if (bus.r1_rvalid) begin
         if (q1.size() == 0) chk("r1 unexpected rvalid", 1, 0);
         else begin
            e = q1.pop_front();
            chk("r1 rdata", bus.r1_rdata, e.d);
            chk("r1 latency", 64'(cyc), 64'(e.c));
         end
      end
   end
   task automatic req(int p, logic w, logic [AW-1:0] a, logic [DW-1:0] wd, logic [DW-1:0] e);
      if (p == 0) begin
         bus.r0_req = 1; bus.r0_we = w; bus.r0_addr = a; bus.r0_wdata = wd; e0 = e;
      end else begin
         bus.r1_req = 1; bus.r1_we = w; bus.r1_addr = a; bus.r1_wdata = wd; e1 = e;
      end
   endtask
   task automatic step();
      @(negedge clk);
      sg0 = bus.r0_gnt;
      sg1 = bus.r1_gnt;
      if (sg0 && !bus.r0_we) q0.push_back('{e0, cyc + LAT + 1});
      if (sg1 && !bus.r1_we) q1.push_back('{e1, cyc + LAT + 1});
      @(posedge clk);
      #1;
      if (sg0) bus.r0_req = 0;
      if (sg1) bus.r1_req = 0;
   endtask
   task automatic idle(int n);
      repeat (n) step();
   endtask
   task automatic chk_zero(string tag);
      chk({tag, " ctl"}, 64'({bus.BRAM_en, bus.BRAM_we, bus.r0_gnt, bus.r1_gnt,
                             bus.r0_rvalid, bus.r1_rvalid, bus.busy}), 0);
      chk({tag, " addr"}, 64'(bus.BRAM_addr), 0);
      chk({tag, " din"}, bus.BRAM_din, 0);
   endtask
   initial begin
      for (int i = 0; i < (1 << (BAW-2)); i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
      for (int i = 0; i < LAT; i++) rq[i] = '0;
      {bus.r0_req, bus.r0_we, bus.r0_addr, bus.r0_wdata} = '0;
      {bus.r1_req, bus.r1_we, bus.r1_addr, bus.r1_wdata} = '0;
      e0 = '0; e1 = '0;
      #1 rst = 0;
      bus.r0_req = 1; bus.r1_req = 1;
      #2 chk_zero("reset");
      @(posedge clk); #1;
      bus.r0_req = 0; bus.r1_req = 0; rst = 1;
      // contention: both ports request every cycle
      n0 = 0; n1 = 0;
      for (int i = 0; i < 8; i++) begin
         req(0, 0, 10, 0, 64'hA5A5_0000_0000_000A);
         req(1, 0, 11, 0, 64'hA5A5_0000_0000_000B);
         step();
         chk("contention gnt0", sg0, FIXED ? 1'b1 : (i % 2 == 0));
         chk("contention gnt1", sg1, FIXED ? 1'b0 : (i % 2 == 1));
         n0 += int'(sg0); n1 += int'(sg1);
      end
      bus.r0_req = 0; bus.r1_req = 0;
      chk("contention count0", 64'(n0), FIXED ? 8 : 4);
      chk("contention count1", 64'(n1), FIXED ? 0 : 4);
      idle(6);
      // single read, issue stage contents
      req(0, 0, 5, 0, 64'hA5A5_0000_0000_0005);
      step();
      chk("single gnt", sg0, 1);
      chk("single BRAM_addr", 64'(bus.BRAM_addr), 20);
      chk("single BRAM_en/we", {bus.BRAM_en, bus.BRAM_we}, 2'b10);
      step();
      chk("idle BRAM_en", bus.BRAM_en, 0);
      chk("idle addr hold", 64'(bus.BRAM_addr), 20);
      idle(5);
      // write then read on port 1
      req(1, 1, 100, 64'hDEADBEEF_00000001, 0);
      step();
      chk("write gnt", sg1, 1);
      chk("write strobe", {bus.BRAM_en, bus.BRAM_we}, 2'b11);
      chk("write din", bus.BRAM_din, 64'hDEADBEEF_00000001);
      req(1, 0, 100, 0, 64'hDEADBEEF_00000001);
      step();
      idle(5);
      // read then write same address: read returns the old value
      req(0, 0, 100, 0, 64'hDEADBEEF_00000001);
      step();
      req(0, 1, 100, 64'h1111_2222_3333_4444, 0);
      step();
      req(0, 0, 100, 0, 64'h1111_2222_3333_4444);
      step();
      idle(5);
      // interleaved return order and busy
      req(0, 0, 1, 0, 64'hA5A5_0000_0000_0001);
      step();
      req(1, 0, 2, 0, 64'hA5A5_0000_0000_0002);
      step();
      req(0, 0, 3, 0, 64'hA5A5_0000_0000_0003);
      step();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("interleave busy", bus.busy, k < 4);
         @(posedge clk); #1;
      end
      // continuous port 0 with a waiting port 1
      for (int i = 0; i < 6; i++) begin
         req(0, 0, 20, 0, 64'hA5A5_0000_0000_0014);
         if (i == 0) req(1, 0, 21, 0, 64'hA5A5_0000_0000_0015);
         step();
         chk("prio gnt0", sg0, FIXED ? 1'b1 : (i != 0));
         chk("prio gnt1", sg1, FIXED ? 1'b0 : (i == 0));
      end
      bus.r0_req = 0;
      step();
      chk("prio late gnt1", sg1, FIXED);
      idle(6);
      // reset mid-stream discards in-flight reads
      req(0, 0, 7, 0, 64'hA5A5_0000_0000_0007);
      step();
      req(1, 0, 8, 0, 64'hA5A5_0000_0000_0008);
      step();
      req(0, 0, 9, 0, 64'hA5A5_0000_0000_0009);
      #1 rst = 0;
      #1 chk_zero("midreset");
      q0.delete(); q1.delete();
      @(posedge clk); @(posedge clk); #1;
      bus.r0_req = 0; bus.r1_req = 0; rst = 1;
      idle(8);
      chk("q0 drained", 64'(q0.size()), 0);
      chk("q1 drained", 64'(q1.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
